// File: rtl/rom_ram_copy_engine.sv
// ROM-to-RAM block copy engine, one byte per cycle, ROM latency pipelined.
// Optional checksum output enabled by defining COPY_CHECKSUM_EN.
module rom_ram_copy_engine #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
`ifdef COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [DATA_W-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN =
    {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_n;

  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W:0]   cnt_q, cnt_n;
  logic [ADDR_W-1:0] dst_q, dst_n;
  logic              busy_n, done_n;
  logic              rom_en_n, ram_we_n;
  logic [ADDR_W-1:0] rom_addr_n, ram_addr_n;
  logic [ADDR_W:0]   len_sat;
  logic              accept;

  assign len_sat = (length > MAX_LEN) ? MAX_LEN : length;
  assign accept  = (state == IDLE) && start;

  // ROM data lands in the same cycle as the matching write strobe
  assign ram_data = ram_we ? rom_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      dst_q    <= dst_n;
      busy     <= busy_n;
      done     <= done_n;
      rom_en   <= rom_en_n;
      rom_addr <= rom_addr_n;
      ram_we   <= ram_we_n;
      ram_addr <= ram_addr_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start)
          state_n = (len_sat == '0) ? FIN : RUN;
      RUN:
        if (cnt_q == len_q)
          state_n = DRAIN;
      DRAIN: state_n = FIN;
      FIN:   state_n = IDLE;
    endcase
  end

  always_comb begin
    len_n      = len_q;
    cnt_n      = cnt_q;
    dst_n      = dst_q;
    busy_n     = busy;
    done_n     = 1'b0;
    rom_en_n   = rom_en;
    rom_addr_n = rom_addr;
    ram_we_n   = ram_we;
    ram_addr_n = ram_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          len_n      = len_sat;
          dst_n      = dst_base;
          rom_addr_n = src_base;
          cnt_n      = '0;
          if (len_sat == '0) begin
            done_n = 1'b1;
          end else begin
            busy_n   = 1'b1;
            rom_en_n = 1'b1;
            cnt_n    = 1;
          end
        end
      end
      RUN: begin
        // each issued read becomes a write one cycle later
        ram_we_n   = 1'b1;
        ram_addr_n = ram_we ? ram_addr + 1'b1 : dst_q;
        if (cnt_q == len_q) begin
          rom_en_n = 1'b0;
        end else begin
          rom_addr_n = rom_addr + 1'b1;
          cnt_n      = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        ram_we_n = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b1;
      end
      FIN: begin
        busy_n = 1'b0;
      end
    endcase
  end

`ifdef COPY_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept)
      checksum <= '0;
    else if (ram_we)
      checksum <= checksum + rom_data;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
